// File: rtl/demux_dispatcher.sv
// demux_dispatcher: FIFO-buffered valid/ready front end that feeds a demux's data/select through a registered output stage.
// Define DEMUX_DISPATCH_STATS_EN to enable saturating accept/drop counters on stat_acc/stat_drop.

module demux_dispatcher #(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned NUM_OUTS = 16,
    parameter int unsigned SEL_W    = ($clog2(NUM_OUTS) > 0 ? $clog2(NUM_OUTS) : 1),
    parameter int unsigned DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_dest,
    input  logic                   rr_mode,
    output logic [DATA_W-1:0]      dout,
    output logic [SEL_W-1:0]       sel,
    output logic                   dout_valid,
    input  logic [NUM_OUTS-1:0]    dst_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_dest,
    output logic [15:0]            stat_acc,
    output logic [15:0]            stat_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEL_W-1:0]  mem_sel  [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;
    logic [SEL_W-1:0]  rr_ptr;

    logic              fifo_empty;
    logic              full;
    logic              accept;
    logic              dest_oor;
    logic              drop;
    logic              push;
    logic [SEL_W-1:0]  dest;
    logic              retire;
    logic              load;
    logic              pop;
    logic              bypass;
    logic              wr_en;

    // Handshake, destination resolution and output-register load decisions.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        full       = (fifo_count == CW'(DEPTH));
        in_ready   = !rst && !full;
        accept     = in_valid && in_ready;
        dest_oor   = ({1'b0, in_dest} >= (SEL_W + 1)'(NUM_OUTS));
        dest       = rr_mode ? rr_ptr : in_dest;
        drop       = accept && !rr_mode && dest_oor;
        push       = accept && !drop;
        retire     = dout_valid && dst_ready[sel];
        load       = !dout_valid || retire;
        pop        = load && !fifo_empty;
        // Bypass straight into the output register only when nothing is queued ahead.
        bypass     = load && fifo_empty && push;
        wr_en      = push && !bypass;
    end

    assign level = fifo_count + CW'(dout_valid);

    // Storage array needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= in_data;
            mem_sel[wr_ptr]  <= dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_ptr     <= '0;
            dout       <= '0;
            sel        <= '0;
            dout_valid <= 1'b0;
            err_dest   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (pop) begin
                dout       <= mem_data[rd_ptr];
                sel        <= mem_sel[rd_ptr];
                dout_valid <= 1'b1;
            end else if (bypass) begin
                dout       <= in_data;
                sel        <= dest;
                dout_valid <= 1'b1;
            end else if (load) begin
                dout_valid <= 1'b0;
            end

            if (accept && rr_mode) begin
                rr_ptr <= (rr_ptr == SEL_W'(NUM_OUTS - 1)) ? '0 : rr_ptr + SEL_W'(1);
            end
            if (drop) begin
                err_dest <= 1'b1;
            end
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    // Saturating counters; dropped words still count as accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_acc  <= '0;
            stat_drop <= '0;
        end else begin
            if (accept && (stat_acc != 16'hFFFF)) begin
                stat_acc <= stat_acc + 16'd1;
            end
            if (drop && (stat_drop != 16'hFFFF)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`else
    assign stat_acc  = '0;
    assign stat_drop = '0;
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: a word-queue reference model predicts handshakes/levels,
// and a separate monitor checks every retired word against the expected-output queue.

module tb_demux_dispatcher;

    localparam int DATA_W   = 8;
    localparam int NUM_OUTS = 12;
    localparam int SEL_W    = 4;
    localparam int DEPTH    = 4;
    localparam int LW       = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [SEL_W-1:0]     in_dest;
    logic                 rr_mode;
    logic [DATA_W-1:0]    dout;
    logic [SEL_W-1:0]     sel;
    logic                 dout_valid;
    logic [NUM_OUTS-1:0]  dst_ready;
    logic [LW-1:0]        level;
    logic                 err_dest;
    logic [15:0]          stat_acc;
    logic [15:0]          stat_drop;

    demux_dispatcher #(
        .DATA_W(DATA_W), .NUM_OUTS(NUM_OUTS), .SEL_W(SEL_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
        .rr_mode(rr_mode),
        .dout(dout), .sel(sel), .dout_valid(dout_valid), .dst_ready(dst_ready),
        .level(level), .err_dest(err_dest), .stat_acc(stat_acc), .stat_drop(stat_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } word_t;

    word_t mq[$];   // words held by the dispatcher, oldest first
    word_t sb[$];   // expected output stream for the monitor
    int    checks   = 0;
    int    failures = 0;
    int    m_rr     = 0;
    bit    m_err    = 1'b0;
    int    m_acc    = 0;
    int    m_drop   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] dst,
                         input bit rr, input logic [NUM_OUTS-1:0] rdy);
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        rr_mode   = rr;
        dst_ready = rdy;
    endtask

    task automatic check_stats();
`ifdef DEMUX_DISPATCH_STATS_EN
        chk("stat_acc", 32'(stat_acc), 32'(m_acc));
        chk("stat_drop", 32'(stat_drop), 32'(m_drop));
`else
        chk("stat_acc_tied", 32'(stat_acc), 32'(0));
        chk("stat_drop_tied", 32'(stat_drop), 32'(0));
`endif
    endtask

    // Called just after a rising edge with inputs driven: check mid-cycle, then apply the next edge to the model.
    task automatic step();
        int    n;
        bit    ret;
        bit    acc;
        word_t w;
        @(negedge clk);
        n = mq.size();
        chk("in_ready", 32'(in_ready), 32'(n <= DEPTH));
        chk("level", 32'(level), 32'(n));
        chk("dout_valid", 32'(dout_valid), 32'(n > 0));
        chk("err_dest", 32'(err_dest), 32'(m_err));
        if (n > 0) begin
            chk("sel_head", 32'(sel), 32'(mq[0].sel));
            chk("dout_head", 32'(dout), 32'(mq[0].data));
        end
        check_stats();
        ret = 1'b0;
        if (n > 0) ret = dst_ready[mq[0].sel];
        acc = in_valid && (n <= DEPTH);
        if (ret) void'(mq.pop_front());
        if (acc) begin
            m_acc++;
            w.data = in_data;
            if (rr_mode) begin
                w.sel = SEL_W'(m_rr);
                m_rr  = (m_rr + 1) % NUM_OUTS;
                mq.push_back(w);
                sb.push_back(w);
            end else if (int'(in_dest) >= NUM_OUTS) begin
                m_err = 1'b1;
                m_drop++;
            end else begin
                w.sel = in_dest;
                mq.push_back(w);
                sb.push_back(w);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'(0));
        chk({tag, "_level"}, 32'(level), 32'(0));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        chk({tag, "_err_dest"}, 32'(err_dest), 32'(0));
        chk({tag, "_dout"}, 32'(dout), 32'(0));
        chk({tag, "_sel"}, 32'(sel), 32'(0));
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        m_rr   = 0;
        m_err  = 1'b0;
        m_acc  = 0;
        m_drop = 0;
    endtask

    task automatic random_cycles(input int count, input bit allow_oor);
        logic [NUM_OUTS-1:0] rdy;
        logic [SEL_W-1:0]    dst;
        for (int i = 0; i < count; i++) begin
            case ($urandom % 4)
                0:       rdy = '1;
                1:       rdy = '0;
                default: rdy = NUM_OUTS'($urandom);
            endcase
            dst = allow_oor ? SEL_W'($urandom_range(0, 15)) : SEL_W'($urandom_range(0, NUM_OUTS - 1));
            drive(($urandom % 4) != 0, DATA_W'($urandom), dst, 1'($urandom), rdy);
            step();
        end
    endtask

    // Monitor: every DUT retire must match the next expected word.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (!rst && dout_valid && dst_ready[sel]) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected at %0t: actual sel=%0d dout=0x%0h required none", $time, sel, dout);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sel", 32'(sel), 32'(e.sel));
                    chk("sb_data", 32'(dout), 32'(e.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        rst = 1'b0;

        // Addressed single word to destination 5
        drive(1'b1, 8'h01, 4'd5, 1'b0, 12'h020);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0, 12'h020);
        repeat (2) step();

        // Round-robin run past the wrap point
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, DATA_W'($urandom), 4'd0, 1'b1, '1);
            step();
        end
        drive(1'b0, 8'h00, 4'd0, 1'b1, '1);
        repeat (3) step();

        // Backpressure until full, then release
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DATA_W'(8'h40 + i), SEL_W'($urandom_range(0, NUM_OUTS - 1)), 1'b0, '0);
            step();
        end
        drive(1'b0, 8'h00, 4'd0, 1'b0, '0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0, '1);
        repeat (6) step();

        // Stall hold on sel=3 while every other destination is ready
        drive(1'b1, 8'hA5, 4'd3, 1'b0, 12'hFF7);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0, 12'hFF7);
        repeat (10) step();
        drive(1'b0, 8'h00, 4'd0, 1'b0, '1);
        repeat (2) step();

        // Out-of-range destination is dropped and flagged
        drive(1'b1, 8'h77, 4'd13, 1'b0, '1);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b0, '1);
        repeat (3) step();

        random_cycles(400, 1'b0);

        // Build level=3 and reset asynchronously between edges
        drive(1'b0, 8'h00, 4'd0, 1'b1, '1);
        repeat (DEPTH + 3) step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DATA_W'(8'h90 + i), 4'd0, 1'b1, '0);
            step();
        end
        drive(1'b0, 8'h00, 4'd0, 1'b1, '0);
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'h5C, 4'd7, 1'b1, '0);
        step();
        drive(1'b0, 8'h00, 4'd0, 1'b1, '1);
        repeat (2) step();

        random_cycles(300, 1'b1);

        drive(1'b0, 8'h00, 4'd0, 1'b0, '1);
        repeat (DEPTH + 3) step();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
